// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending-write scoreboard; r0 reads as zero.
// Define REGFILE_BYPASS_EN to forward a same-cycle WB write to the read ports and busy flags.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_waddr,
    output logic              issue_ready,
    output logic              wb_underflow
);
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [DATA_W-1:0] DATA_ZERO = '0;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic [CNT_W-1:0]  cnt_d  [DEPTH];
    logic              underflow_q;
    logic              underflow_d;
    logic              wr_s;
    logic              inc_s;
    logic              dec_s;
    logic              hit1_s;
    logic              hit2_s;

    assign wr_s         = we && (waddr != ADDR_ZERO);
    assign issue_ready  = (issue_waddr == ADDR_ZERO) || (cnt_q[issue_waddr] != CNT_MAX);
    assign inc_s        = issue_we && issue_ready && (issue_waddr != ADDR_ZERO);
    assign dec_s        = wr_s && (cnt_q[waddr] != CNT_ZERO);
    assign wb_underflow = underflow_q;

    // Next-state pending counters; a same-register inc and dec cancel out.
    always_comb begin
        cnt_d[0] = CNT_ZERO;
        for (int i = 1; i < DEPTH; i++) begin
            case ({inc_s && (issue_waddr == ADDR_W'(i)), dec_s && (waddr == ADDR_W'(i))})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Sticky underflow: a retiring write found no pending issue for its register.
    always_comb begin
        underflow_d = underflow_q || (wr_s && (cnt_q[waddr] == CNT_ZERO));
    end

    // Storage, counters and the error flag; reset discards everything, including same-cycle writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= DATA_ZERO;
                cnt_q[i]  <= CNT_ZERO;
            end
            underflow_q <= 1'b0;
        end else begin
            if (wr_s) begin
                regs_q[waddr] <= wdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            underflow_q <= underflow_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign hit1_s = dec_s && (waddr == raddr1);
    assign hit2_s = dec_s && (waddr == raddr2);
`else
    assign hit1_s = 1'b0;
    assign hit2_s = 1'b0;
`endif

    // Read port 1: zero register, optional WB forwarding, then storage.
    always_comb begin
        if (raddr1 == ADDR_ZERO) begin
            rdata1 = DATA_ZERO;
`ifdef REGFILE_BYPASS_EN
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
`endif
        end else begin
            rdata1 = regs_q[raddr1];
        end
        busy1 = (raddr1 != ADDR_ZERO) && (cnt_q[raddr1] > CNT_W'(hit1_s));
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        if (raddr2 == ADDR_ZERO) begin
            rdata2 = DATA_ZERO;
`ifdef REGFILE_BYPASS_EN
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
`endif
        end else begin
            rdata2 = regs_q[raddr2];
        end
        busy2 = (raddr2 != ADDR_ZERO) && (cnt_q[raddr2] > CNT_W'(hit2_s));
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations, a negedge monitor pops and checks them.
// Expectations follow REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  raddr1, raddr2, waddr, issue_waddr;
    logic [31:0] rdata1, rdata2, wdata;
    logic        busy1, busy2, we, issue_we, issue_ready, wb_underflow;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .busy1(busy1), .busy2(busy2),
        .we(we), .waddr(waddr), .wdata(wdata),
        .issue_we(issue_we), .issue_waddr(issue_waddr), .issue_ready(issue_ready),
        .wb_underflow(wb_underflow)
    );

    always #5 clk = ~clk;

    // Monitor: compare every expectation queued for this cycle against live outputs.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.sel)
                0:       act = rdata1;
                1:       act = rdata2;
                2:       act = {31'd0, busy1};
                3:       act = {31'd0, busy2};
                4:       act = {31'd0, issue_ready};
                5:       act = {31'd0, wb_underflow};
                default: act = 32'hxxxxxxxx;
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h at %0t", e.name, act, e.val, $time);
            end
        end
    end

    task automatic expect_(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name; e.sel = sel; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; issue_we = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d; issue_we = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a);
        issue_we = 1'b1; issue_waddr = a; we = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; raddr1 = 5'd3; raddr2 = 5'd0; waddr = 5'd0; wdata = 32'd0;
        issue_waddr = 5'd3; idle();
        #1;
        n_cmp++;
        if (rdata1 !== 32'd0) begin
            n_fail++;
            $display("FAIL por_direct_rdata1: got %h, expected %h at %0t", rdata1, 32'd0, $time);
        end
        n_cmp++;
        if (issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL por_direct_ready: got %b, expected %b at %0t", issue_ready, 1'b1, $time);
        end
        expect_("por_rdata1", 0, 32'd0); expect_("por_busy1", 2, 32'd0);
        expect_("por_ready", 4, 32'd1);  expect_("por_uf", 5, 32'd0);
        step();
        rst = 1'b0;

        // Register 0: writes dropped, issues ignored.
        wb(5'd0, 32'hFFFFFFFF); issue_we = 1'b1; issue_waddr = 5'd0;
        raddr1 = 5'd0; raddr2 = 5'd0;
        expect_("r0_rdata1", 0, 32'd0); expect_("r0_rdata2", 1, 32'd0);
        expect_("r0_busy1", 2, 32'd0);  expect_("r0_ready", 4, 32'd1);
        step(); idle();
        expect_("r0_rdata1_after", 0, 32'd0); expect_("r0_busy1_after", 2, 32'd0);
        expect_("r0_ready_after", 4, 32'd1);  expect_("r0_uf", 5, 32'd0);
        step();

        // Scoreboard lifecycle on r7.
        raddr1 = 5'd7;
        issue(5'd7);
        expect_("r7_busy_c0", 2, 32'd0); expect_("r7_ready_c0", 4, 32'd1);
        step();
        expect_("r7_busy_c1", 2, 32'd1); expect_("r7_ready_c1", 4, 32'd1);
        step(); idle();
        expect_("r7_busy_c2", 2, 32'd1); expect_("r7_ready_c2", 4, 32'd1);
        step();
        wb(5'd7, 32'h70);
        expect_("r7_wb1_busy", 2, 32'd1); expect_("r7_wb1_rdata", 0, BYP ? 32'h70 : 32'd0);
        step();
        wb(5'd7, 32'h71);
        expect_("r7_wb2_busy", 2, BYP ? 32'd0 : 32'd1);
        expect_("r7_wb2_rdata", 0, BYP ? 32'h71 : 32'h70);
        step(); idle();
        expect_("r7_done_busy", 2, 32'd0); expect_("r7_done_rdata", 0, 32'h71);
        step();
        issue(5'd7);
        step();
        wb(5'd7, 32'h72); issue_we = 1'b1; issue_waddr = 5'd7;
        expect_("r7_simul_busy", 2, BYP ? 32'd0 : 32'd1);
        step(); idle();
        expect_("r7_simul_hold_busy", 2, 32'd1); expect_("r7_simul_rdata", 0, 32'h72);
        step();
        wb(5'd7, 32'h73);
        expect_("r7_last_busy", 2, BYP ? 32'd0 : 32'd1);
        step(); idle();
        expect_("r7_last_idle_busy", 2, 32'd0);
        step();

        // Saturation on r9.
        raddr2 = 5'd9;
        issue(5'd9);
        expect_("r9_ready_0", 4, 32'd1); expect_("r9_busy_0", 3, 32'd0);
        step();
        expect_("r9_ready_1", 4, 32'd1); expect_("r9_busy_1", 3, 32'd1);
        step();
        expect_("r9_ready_2", 4, 32'd1);
        step();
        expect_("r9_ready_sat", 4, 32'd0); expect_("r9_busy_sat", 3, 32'd1);
        step(); idle();
        expect_("r9_ready_sat_hold", 4, 32'd0);
        step();
        wb(5'd9, 32'h91);
        expect_("r9_wb1_busy", 3, 32'd1); expect_("r9_wb1_ready", 4, 32'd0);
        step();
        wb(5'd9, 32'h92);
        expect_("r9_wb2_busy", 3, 32'd1); expect_("r9_wb2_ready", 4, 32'd1);
        step();
        wb(5'd9, 32'h93);
        expect_("r9_wb3_busy", 3, BYP ? 32'd0 : 32'd1);
        step(); idle();
        expect_("r9_final_busy", 3, 32'd0); expect_("r9_final_rdata", 1, 32'h93);
        expect_("uf_clear_before", 5, 32'd0);
        step();

        // Underflow on r4.
        raddr1 = 5'd4;
        wb(5'd4, 32'h12);
        expect_("uf_wb_rdata", 0, BYP ? 32'h12 : 32'd0); expect_("uf_wb_flag", 5, 32'd0);
        step(); idle();
        expect_("uf_rdata", 0, 32'h12); expect_("uf_flag", 5, 32'd1);
        expect_("uf_busy", 2, 32'd0);
        step();
        expect_("uf_flag_hold", 5, 32'd1);
        step();

        // Write/read bypass on r5.
        raddr1 = 5'd5; raddr2 = 5'd4;
        wb(5'd5, 32'hDEADBEEF);
        expect_("byp_rdata1", 0, BYP ? 32'hDEADBEEF : 32'd0);
        expect_("byp_rdata2", 1, 32'h12);
        step(); idle();
        expect_("byp_after", 0, 32'hDEADBEEF); expect_("byp_uf", 5, 32'd1);
        step();

        // Mid-run reset with cnt[3]=2 and reg[3]=0x55.
        raddr1 = 5'd3;
        issue(5'd3); step(); step(); step();
        wb(5'd3, 32'h55); step(); idle();
        issue_waddr = 5'd3;
        expect_("pre_rst_busy", 2, 32'd1); expect_("pre_rst_rdata", 0, 32'h55);
        expect_("pre_rst_ready", 4, 32'd1);
        step();
        rst = 1'b1;
        expect_("rst_rdata1", 0, 32'd0); expect_("rst_busy1", 2, 32'd0);
        expect_("rst_ready", 4, 32'd1);  expect_("rst_uf", 5, 32'd0);
        step();
        rst = 1'b0;
        expect_("post_rst_rdata1", 0, 32'd0); expect_("post_rst_busy1", 2, 32'd0);
        expect_("post_rst_ready", 4, 32'd1);  expect_("post_rst_uf", 5, 32'd0);
        step();
        n_cmp++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_direct_busy1: got %b, expected %b at %0t", busy1, 1'b0, $time);
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
